// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver presenting each byte on a valid/ready holding register
//   clk       : system clock, all logic on the rising edge
//   rst       : synchronous active-high reset
//   rx        : asynchronous serial line, idle high
//   rx_data   : last received byte
//   rx_valid  : rx_data holds an unconsumed byte
//   rx_ready  : consumer accepts the byte when rx_valid && rx_ready
//   frame_err : one-clock pulse, stop bit sampled low
//   overrun   : one-clock pulse, a new byte replaced an unconsumed one
//   busy      : receiver is inside a frame (state != IDLE)
module uart_rx #(
    parameter int max_clk   = 10000000,
    parameter int baud_rate = 9600,
    parameter int baud_max  = max_clk / baud_rate
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam logic [15:0] FULL = 16'(baud_max);
    localparam logic [15:0] HALF = 16'(baud_max / 2);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
    state_t      state;
    logic [15:0] cnt;
    logic [2:0]  idx;
    logic [7:0]  sh;
    logic        rx_m, rx_s;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            sh        <= '0;
            rx_m      <= 1'b1;
            rx_s      <= 1'b1;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            {rx_s, rx_m} <= {rx_m, rx};
            cnt          <= cnt + 16'd1;
            frame_err    <= 1'b0;
            overrun      <= 1'b0;
            // a delivery later in this block overrides this clear
            if (rx_valid && rx_ready) rx_valid <= 1'b0;
            case (state)
                IDLE: if (!rx_s) begin
                    state <= START;
                    cnt   <= '0;
                    busy  <= 1'b1;
                end
                // mid start bit: a line already back high was only a glitch
                START: if (cnt == HALF) begin
                    cnt   <= '0;
                    idx   <= '0;
                    state <= rx_s ? IDLE : DATA;
                    busy  <= !rx_s;
                end
                DATA: if (cnt == FULL) begin
                    cnt   <= '0;
                    sh    <= {rx_s, sh[7:1]};
                    idx   <= idx + 3'd1;
                    state <= (idx == 3'd7) ? STOP : DATA;
                end
                STOP: if (cnt == FULL) begin
                    cnt       <= '0;
                    state     <= rx_s ? IDLE : BREAK;
                    busy      <= !rx_s;
                    frame_err <= !rx_s;
                    if (rx_s) begin
                        rx_data  <= sh;
                        rx_valid <= 1'b1;
                        overrun  <= rx_valid && !rx_ready;
                    end
                end
                // hold off until the line idles so a stuck-low rx cannot retrigger
                BREAK: if (rx_s) begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx
module tb_uart_rx;
    localparam int PER = 101;
    localparam int LAT = 3 + 51 + 9 * PER;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, busy;
    int         n_cmp = 0, n_err = 0;
    int         cyc = 0, t0 = 0;
    int         nv = 0, nvh = 0, nfe = 0, nov = 0;
    int         vrise = 0, brise = 0, bfall = 0, fec = 0;
    logic       pv = 1'b0, pb = 1'b0;
    logic [7:0] q[$];

    uart_rx #(.max_clk(100000), .baud_rate(1000)) dut (
        .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid && (!pv || overrun)) q.push_back(rx_data);
        if (rx_valid && !pv) begin nv++; vrise = cyc; end
        if (rx_valid) nvh++;
        if (frame_err) begin nfe++; fec = cyc; end
        if (overrun) nov++;
        if (busy && !pb) brise = cyc;
        if (!busy && pb) bfall = cyc;
        pv = rx_valid;
        pb = busy;
    end

    task automatic check(input string tag, input int obs, input int exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        q.delete();
        nv = 0; nvh = 0; nfe = 0; nov = 0;
    endtask

    // start bit, 8 data bits LSB first, then nstop stop periods at level stop
    task automatic send(input logic [7:0] b, input int per, input logic stop, input int nstop);
        rx = 1'b0;
        t0 = cyc;
        wait_clk(per);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clk(per);
        end
        rx = stop;
        wait_clk(per * nstop);
    endtask

    initial begin
        logic [7:0] lb[4];
        int lat, th;
        lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h55; lb[3] = 8'h81;
        wait_clk(3);
        rst = 1'b0;
        check("rst_data", rx_data, 0);
        check("rst_valid", rx_valid, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun, 0);
        check("rst_busy", busy, 0);
        wait_clk(10);

        clr();
        send(8'hA5, PER, 1'b1, 1);
        wait_clk(100);
        lat = vrise - t0;
        check("a5_n", q.size(), 1);
        check("a5_data", q[0], 8'hA5);
        check("a5_lat", (lat >= LAT - 2 && lat <= LAT + 2) ? LAT : lat, LAT);
        check("a5_vhigh", nvh, 1);
        check("a5_busy_rise", brise - t0, 3);
        check("a5_ferr", nfe, 0);
        check("a5_ovr", nov, 0);

        clr();
        for (int i = 0; i < 4; i++) send(lb[i], PER, 1'b1, 2);
        wait_clk(50);
        check("lb_n", q.size(), 4);
        for (int i = 0; i < 4; i++) check($sformatf("lb_data%0d", i), q[i], lb[i]);
        check("lb_ferr", nfe, 0);
        check("lb_ovr", nov, 0);

        clr();
        rx = 1'b0;
        t0 = cyc;
        wait_clk(30);
        rx = 1'b1;
        wait_clk(30);
        check("gl_busy", busy, 0);
        check("gl_rise", brise - t0, 3);
        check("gl_fall", bfall - t0, 54);
        check("gl_valid", nv, 0);
        check("gl_ferr", nfe, 0);

        clr();
        send(8'h3C, PER, 1'b0, 1);
        wait_clk(500);
        check("fe_busy_low", busy, 1);
        rx = 1'b1;
        th = cyc;
        wait_clk(20);
        check("fe_count", nfe, 1);
        check("fe_at", fec - t0, LAT);
        check("fe_valid", nv, 0);
        check("fe_busy_fall", bfall - th, 3);

        clr();
        rx_ready = 1'b0;
        send(8'h11, PER, 1'b1, 1);
        send(8'h22, PER, 1'b1, 1);
        check("ov_count", nov, 1);
        check("ov_data", rx_data, 8'h22);
        check("ov_valid", rx_valid, 1);
        check("ov_n", q.size(), 2);
        check("ov_q0", q[0], 8'h11);
        check("ov_q1", q[1], 8'h22);
        rx_ready = 1'b1;
        wait_clk(1);
        check("ov_drop", rx_valid, 0);
        check("ov_hold", rx_data, 8'h22);

        rx_ready = 1'b0;
        send(8'h99, PER, 1'b1, 1);
        check("pre_valid", rx_valid, 1);
        rx = 1'b0;
        wait_clk(PER);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            wait_clk(PER);
        end
        rx = 1'b1;
        wait_clk(50);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        check("mr_data", rx_data, 0);
        check("mr_valid", rx_valid, 0);
        check("mr_busy", busy, 0);
        check("mr_ferr", frame_err, 0);
        check("mr_ovr", overrun, 0);
        clr();
        wait_clk(1200);
        check("mr_nv", nv, 0);
        check("mr_nfe", nfe, 0);
        rx_ready = 1'b1;
        send(8'h7E, PER, 1'b1, 1);
        wait_clk(50);
        check("mr_n", q.size(), 1);
        check("mr_7e", q[0], 8'h7E);

        clr();
        send(8'hC3, PER - 2, 1'b1, 1);
        send(8'h3C, PER + 2, 1'b1, 1);
        wait_clk(50);
        check("bt_n", q.size(), 2);
        check("bt_fast", q[0], 8'hC3);
        check("bt_slow", q[1], 8'h3C);
        check("bt_ferr", nfe, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
